// File: rtl/shifter_seq.sv
// -----------------------------------------------------------------------------
// shifter_seq
// Multi-cycle shift/rotate unit. It accepts one operand with a valid/ready
// handshake, shifts it by up to STEP positions per clock and presents the
// result with carry/zero/negative flags on a second valid/ready handshake.
// The unit sits between the register-file read path and the ALU B operand.
//
// Ports
//    clk        rising-edge clock
//    reset_n    asynchronous active-low reset
//    in_valid   request valid
//    in_ready   unit idle, can accept a request
//    din        operand
//    mode       000 pass, 001 LSL, 010 LSR, 011 ASR, 100 ROR, 101 ROL,
//               110/111 reserved (behave as pass)
//    amt        shift amount, 0..WIDTH-1
//    out_valid  result valid
//    out_ready  consumer accepts result
//    dout       result
//    c_out      last bit shifted/rotated out
//    z_out      dout == 0
//    n_out      dout[WIDTH-1]
//
// WIDTH must be a power of two and at least 4; STEP is 1..WIDTH-1.
// -----------------------------------------------------------------------------
module shifter_seq #(
   parameter int WIDTH = 16,
   parameter int STEP  = 1,
   parameter int AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] din,
   input  logic [2:0]       mode,
   input  logic [AMT_W-1:0] amt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] dout,
   output logic             c_out,
   output logic             z_out,
   output logic             n_out
);

   localparam logic [2:0] MODE_LSL = 3'b001;
   localparam logic [2:0] MODE_LSR = 3'b010;
   localparam logic [2:0] MODE_ASR = 3'b011;
   localparam logic [2:0] MODE_ROR = 3'b100;
   localparam logic [2:0] MODE_ROL = 3'b101;

   localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] work_reg, work_next;
   logic [2:0]       mode_reg, mode_next;
   logic [AMT_W-1:0] rem_reg, rem_next;
   logic             carry_reg, carry_next;
   logic             zero_reg, zero_next;

   // Per-cycle shift amount and the shifted candidates for every mode.
   logic [AMT_W-1:0] k;
   logic [AMT_W-1:0] top_idx;
   logic [WIDTH-1:0] lsl_val, lsr_val, asr_val, ror_val, rol_val;
   logic             shift_mode;

   always_comb begin
      k = (rem_reg < STEP_A) ? rem_reg : STEP_A;
      // WIDTH is a power of two, so WIDTH-k is simply -k modulo 2**AMT_W.
      // k is never 0 while shifting, so top_idx is then in 1..WIDTH-1.
      top_idx = AMT_W'(0) - k;
      lsl_val = work_reg << k;
      lsr_val = work_reg >> k;
      asr_val = $signed(work_reg) >>> k;
      ror_val = (work_reg >> k) | (work_reg << top_idx);
      rol_val = (work_reg << k) | (work_reg >> top_idx);
   end

   // Modes that actually move bits; pass and the reserved codes do not.
   always_comb begin
      shift_mode = (mode == MODE_LSL) || (mode == MODE_LSR) || (mode == MODE_ASR) ||
                   (mode == MODE_ROR) || (mode == MODE_ROL);
   end

   always_comb begin
      state_next = state_reg;
      work_next  = work_reg;
      mode_next  = mode_reg;
      rem_next   = rem_reg;
      carry_next = carry_reg;
      zero_next  = zero_reg;

      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               work_next  = din;
               mode_next  = mode;
               rem_next   = amt;
               carry_next = 1'b0;
               zero_next  = (din == '0);
               state_next = (shift_mode && (amt != '0)) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            rem_next = rem_reg - k;
            // The carry of the final chunk is the last bit to leave the word,
            // which is the original bit n-1 (right) or WIDTH-n (left).
            case (mode_reg)
               MODE_LSL: begin
                  work_next  = lsl_val;
                  carry_next = work_reg[top_idx];
               end
               MODE_LSR: begin
                  work_next  = lsr_val;
                  carry_next = work_reg[k - 1'b1];
               end
               MODE_ASR: begin
                  work_next  = asr_val;
                  carry_next = work_reg[k - 1'b1];
               end
               MODE_ROR: begin
                  work_next  = ror_val;
                  carry_next = work_reg[k - 1'b1];
               end
               MODE_ROL: begin
                  work_next  = rol_val;
                  carry_next = work_reg[top_idx];
               end
               default: begin
                  rem_next = '0;
               end
            endcase
            zero_next = (work_next == '0);
            if (rem_next == '0) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         work_reg  <= '0;
         mode_reg  <= '0;
         rem_reg   <= '0;
         carry_reg <= 1'b0;
         zero_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         work_reg  <= work_next;
         mode_reg  <= mode_next;
         rem_reg   <= rem_next;
         carry_reg <= carry_next;
         zero_reg  <= zero_next;
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign dout      = work_reg;
   assign c_out     = carry_reg;
   assign z_out     = zero_reg;
   assign n_out     = work_reg[WIDTH-1];

endmodule

// File: tb/tb_shifter_seq.sv
// -----------------------------------------------------------------------------
// tb_shifter_seq
// Drives a STEP=1 and a STEP=4 instance of shifter_seq with identical requests
// and checks result, flags and latency of each against a bit-level reference
// model, plus backpressure, reset mid-operation and reserved modes.
// -----------------------------------------------------------------------------
module tb_shifter_seq;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          in_valid;
   logic          out_ready;
   logic [W-1:0]  din;
   logic [2:0]    mode;
   logic [3:0]    amt;

   logic [1:0]    rdy, ov, cq, zq, nq;
   logic [W-1:0]  dq [2];

   int n_cmp = 0;
   int n_err = 0;
   int txn   = 0;

   always #5 clk = ~clk;

   shifter_seq #(.WIDTH(W), .STEP(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[0]),
      .din(din), .mode(mode), .amt(amt), .out_valid(ov[0]), .out_ready(out_ready),
      .dout(dq[0]), .c_out(cq[0]), .z_out(zq[0]), .n_out(nq[0])
   );

   shifter_seq #(.WIDTH(W), .STEP(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[1]),
      .din(din), .mode(mode), .amt(amt), .out_valid(ov[1]), .out_ready(out_ready),
      .dout(dq[1]), .c_out(cq[1]), .z_out(zq[1]), .n_out(nq[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: each result bit defined by where it comes from in the operand.
   function automatic void model(input logic [W-1:0] d, input logic [2:0] m, input int n,
                                 output logic [W-1:0] r, output logic c);
      r = d;
      c = 1'b0;
      if (n == 0 || m == 3'd0 || m > 3'd5) return;
      for (int i = 0; i < W; i++) begin
         case (m)
            3'd1:    r[i] = (i >= n) ? d[i-n] : 1'b0;
            3'd2:    r[i] = (i + n < W) ? d[i+n] : 1'b0;
            3'd3:    r[i] = (i + n < W) ? d[i+n] : d[W-1];
            3'd4:    r[i] = d[(i + n) % W];
            default: r[i] = d[(i - n + W) % W];
         endcase
      end
      c = (m == 3'd1 || m == 3'd5) ? d[W-n] : d[n-1];
   endfunction

   function automatic int exp_lat(input logic [2:0] m, input int n, input int step);
      if (n == 0 || m == 3'd0 || m > 3'd5) return 1;
      return (n + step - 1) / step + 1;
   endfunction

   task automatic run_op(input logic [W-1:0] d, input logic [2:0] m, input logic [3:0] a,
                         input bit hold);
      int            lat [2];
      bit            got [2];
      logic [W-1:0]  dcap [2];
      logic          ccap [2], zcap [2], ncap [2];
      logic [W-1:0]  r;
      logic          cexp;
      int            t;

      t = 0;
      while (rdy != 2'b11 && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      check("in_ready_before", 32'(rdy), 32'h3);

      din       = d;
      mode      = m;
      amt       = a;
      in_valid  = 1'b1;
      out_ready = !hold;
      @(posedge clk); #1;
      in_valid = 1'b0;
      // Busy-time input changes must not disturb the operation.
      din  = W'($urandom);
      mode = 3'($urandom);
      amt  = 4'($urandom);

      got = '{0, 0};
      for (int cyc = 1; cyc <= 40 && !(got[0] && got[1]); cyc++) begin
         for (int i = 0; i < 2; i++) begin
            if (!got[i] && ov[i]) begin
               got[i]  = 1;
               lat[i]  = cyc;
               dcap[i] = dq[i];
               ccap[i] = cq[i];
               zcap[i] = zq[i];
               ncap[i] = nq[i];
            end
         end
         if (!(got[0] && got[1])) begin
            @(posedge clk); #1;
         end
      end

      model(d, m, int'(a), r, cexp);
      for (int i = 0; i < 2; i++) begin
         if (!got[i]) begin
            check($sformatf("timeout_s%0d", i), 0, 1);
         end else begin
            check($sformatf("dout_s%0d", i), 32'(dcap[i]), 32'(r));
            check($sformatf("c_out_s%0d", i), 32'(ccap[i]), 32'(cexp));
            check($sformatf("z_out_s%0d", i), 32'(zcap[i]), 32'(r == '0));
            check($sformatf("n_out_s%0d", i), 32'(ncap[i]), 32'(r[W-1]));
            check($sformatf("latency_s%0d", i), 32'(lat[i]),
                  32'(exp_lat(m, int'(a), (i == 0) ? 1 : 4)));
         end
      end

      if (hold) begin
         for (int h = 0; h < 5; h++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
               check($sformatf("hold_dout_s%0d", i), 32'(dq[i]), 32'(dcap[i]));
               check($sformatf("hold_c_s%0d", i), 32'(cq[i]), 32'(ccap[i]));
               check($sformatf("hold_z_s%0d", i), 32'(zq[i]), 32'(zcap[i]));
               check($sformatf("hold_n_s%0d", i), 32'(nq[i]), 32'(ncap[i]));
            end
            check("hold_out_valid", 32'(ov), 32'h3);
            check("hold_in_ready", 32'(rdy), 32'h0);
         end
         out_ready = 1'b1;
         @(posedge clk); #1;
         check("in_ready_after_release", 32'(rdy), 32'h3);
      end

      $display("txn %0d mode=%0d din=%h amt=%0d hold=%0d exp=%h/%0b s1=%h/%0b lat%0d s4=%h/%0b lat%0d",
               txn, m, d, a, hold, r, cexp, dcap[0], ccap[0], lat[0], dcap[1], ccap[1], lat[1]);
      txn++;
   endtask

   task automatic check_zero_outputs(input string tag);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s_dout_s%0d", tag, i), 32'(dq[i]), 32'h0);
      end
      check({tag, "_c"}, 32'(cq), 32'h0);
      check({tag, "_z"}, 32'(zq), 32'h0);
      check({tag, "_n"}, 32'(nq), 32'h0);
      check({tag, "_out_valid"}, 32'(ov), 32'h0);
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      din       = '0;
      mode      = '0;
      amt       = '0;
      #1;
      check_zero_outputs("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("in_ready_after_reset", 32'(rdy), 32'h3);

      // Directed cases
      run_op(16'h1234, 3'd2, 4'd0,  0);
      run_op(16'h8001, 3'd1, 4'd1,  0);
      run_op(16'h0001, 3'd2, 4'd1,  0);
      run_op(16'h8000, 3'd3, 4'd4,  0);
      run_op(16'h0001, 3'd4, 4'd1,  0);
      run_op(16'h8000, 3'd5, 4'd15, 0);
      run_op(16'hF000, 3'd2, 4'd6,  0);
      run_op(16'hA5C3, 3'd4, 4'd7,  1);
      run_op(16'h0F0F, 3'd1, 4'd9,  0);
      run_op(16'hABCD, 3'd7, 4'd5,  0);
      run_op(16'hABCD, 3'd6, 4'd3,  0);
      run_op(16'h7FFF, 3'd3, 4'd15, 0);

      // Reset two cycles into a long ASR
      din      = 16'h9abc;
      mode     = 3'd3;
      amt      = 4'd10;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      reset_n = 1'b0;
      #1;
      check_zero_outputs("midreset");
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("in_ready_after_midreset", 32'(rdy), 32'h3);
      run_op(16'h0003, 3'd1, 4'd2, 0);

      // Randomized traffic
      for (int r = 0; r < 40; r++) begin
         run_op(W'($urandom), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 4) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/shifter_seq.md
Name: shifter_seq

Overview:
- Parametrised, multi-cycle shift/rotate unit and the successor to the fixed 16-bit combinational shifter.
- Supports variable shift amounts and rotate modes. It shifts STEP bit positions per clock.
- Uses a valid/ready handshake on both sides, and sits between the register-file read path and the ALU `B` operand.
- Also produces carry, zero and negative flags for the status register.

Parameters:
- WIDTH, 16: datapath width. Must be a power of two and at least 4.
- STEP, 1: maximum bit positions shifted per clock. Range 1..WIDTH-1.
- AMT_W, $clog2(WIDTH): shift-amount width. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- din  in  WIDTH  operand
- mode  in  3  000 pass, 001 LSL, 010 LSR, 011 ASR, 100 ROR, 101 ROL, 110/111 reserved
- amt  in  AMT_W  shift amount, 0..WIDTH-1
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- dout  out  WIDTH  result
- c_out  out  1  last bit shifted/rotated out
- z_out  out  1  dout == 0
- n_out  out  1  dout[WIDTH-1]

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE; dout, c_out, z_out, n_out and out_valid go to 0.
  - Any in-flight operation is discarded.
  - in_ready is 1 in the first cycle after reset release.
- States: IDLE, SHIFT, DONE.
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE).
- IDLE:
  - On in_valid & in_ready at an edge, capture din into the work register, plus mode and the remaining count (= amt).
  - If amt == 0 or mode == pass/reserved, go to DONE. Otherwise go to SHIFT.
  - c_out is cleared on accept.
- SHIFT:
  - Each edge shifts by k = min(STEP, remaining) and decrements remaining by k.
  - Go to DONE when remaining reaches 0.
- Latency: out_valid rises ceil(amt/STEP) + 1 edges after the accept edge. For amt == 0 it rises 1 edge after.
- Mode semantics, n = amt:
  - LSL: zero fill from the LSB.
  - LSR: zero fill from the MSB.
  - ASR: MSB replicated into every vacated position.
  - ROR / ROL: circular; no bits are lost.
- Reserved modes (110/111): treated as pass. dout = din, c_out = 0, amt ignored.
- c_out value:
  - LSR, ASR, ROR: original bit n-1.
  - LSL, ROL: original bit WIDTH-n.
  - n == 0 or pass: 0.
- Flags: z_out and n_out are derived from the final dout and are valid whenever out_valid is high.
- DONE:
  - dout, c_out, z_out and n_out stay stable while out_valid & !out_ready.
  - On out_ready, go to IDLE. in_ready rises the cycle after the result handshake, so there is no same-cycle back-to-back accept.
  - Sustained throughput is one result per ceil(amt/STEP) + 2 cycles.
- Input stability: din, mode and amt are sampled only at the accept edge. Changes while busy are ignored.
- Outputs are registered; there is no combinational path from in_valid/din to dout.
- Asserting in_valid in SHIFT/DONE is legal. The request is held off (in_ready = 0) and not lost, provided the requester keeps in_valid asserted.

Test Plan (all scenarios use WIDTH=16 unless stated):
- Pass-through latency: STEP=1, LSR, din=0x1234, amt=0 -> out_valid 1 edge after accept; dout=0x1234, c_out=0, z=0, n=0.
- Logical shift with carry: STEP=1, LSL, din=0x8001, amt=1 -> out_valid 2 edges after accept; dout=0x0002, c_out=1. Also LSR, din=0x0001, amt=1 -> dout=0x0000, c_out=1, z=1.
- Arithmetic and rotate: STEP=1:
  - ASR, 0x8000, amt=4 -> dout 0xF800, c_out=0, n=1, latency 5.
  - ROR, 0x0001, amt=1 -> dout 0x8000, c_out=1.
  - ROL, 0x8000, amt=15 -> dout 0x4000, c_out=0.
- Multi-bit step: STEP=4, LSR, din=0xF000, amt=6 -> exactly 2 SHIFT cycles; dout=0x03C0, c_out=0, out_valid 3 edges after accept.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> dout, c_out, z_out, n_out unchanged and in_ready=0 throughout. Then out_ready=1 for one edge -> in_ready=1 the next cycle. A second request accepted then completes correctly.
- Reset mid-operation and reserved mode:
  - Assert reset_n=0 two cycles into ASR amt=10 -> all outputs 0 immediately and in_ready=1 after release. A new LSL 0x0003 amt=2 gives 0x000C.
  - mode=111, din=0xABCD, amt=5 -> dout=0xABCD, c_out=0, latency 1.
